effect_sample_scheduler: RTL and testbench
==========================================

Name: effect_sample_scheduler

Overview:
- Sample-rate sequencer between the input sample FIFO, one effect datapath (e.g. distortion) and the output sample FIFO.
- On each audio sample tick: pops one sample, starts the effect, waits for completion with a watchdog, pushes the result.
- Keeps the effect path fed at exactly one sample per tick and reports underrun/overrun/timeout/missed-tick events as counters for the Avalon register block.

Parameters:
- DATA_W, 32, sample width.
- TIMEOUT, 64, max clk cycles in RUN waiting for fx_done (>=2).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; low = ticks ignored
- bypass  in  1  pass samples unprocessed; sampled in LOAD
- sample_tick  in  1  one-cycle pulse at audio rate
- clr_stats  in  1  one-cycle pulse, clears all counters and tick_miss
- in_rdempty  in  1  input FIFO empty
- in_rdreq  out  1  input FIFO read request
- in_q  in  DATA_W  input FIFO data, valid one cycle after in_rdreq
- fx_start  out  1  one-cycle start pulse to effect
- fx_in  out  DATA_W  sample to effect, held stable during RUN
- fx_done  in  1  effect result valid (one cycle)
- fx_out  in  DATA_W  effect result
- out_wrfull  in  1  output FIFO full
- out_wrreq  out  1  output FIFO write request
- out_data  out  DATA_W  output FIFO data
- busy  out  1  high whenever state != IDLE
- tick_miss  out  1  sticky: a tick arrived while busy
- underrun_cnt  out  CNT_W  ticks with empty input FIFO
- overrun_cnt  out  CNT_W  samples dropped, output FIFO full
- timeout_cnt  out  CNT_W  effect watchdog expiries

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all request/strobe outputs 0; fx_in=0, out_data=0.
  - All counters 0; tick_miss=0.
- IDLE:
  - sample_tick & enable & !in_rdempty: in_rdreq=1 for one cycle -> POP.
  - sample_tick & enable & in_rdempty: underrun_cnt++; load sample register with 0 (silence) -> PUSH.
  - enable=0: ticks ignored, nothing counted.
- POP (1 cycle): wait for FIFO read latency -> LOAD.
- LOAD (1 cycle):
  - Capture in_q into sample register.
  - bypass=1 -> PUSH with raw sample.
  - Else fx_in<=sample, fx_start pulses next cycle -> RUN.
- RUN:
  - Watchdog counter starts at 0 on entry.
  - fx_done -> capture fx_out -> PUSH.
  - Watchdog reaches TIMEOUT-1 without fx_done: timeout_cnt++; push the raw input sample -> PUSH.
  - fx_done on the expiry cycle: fx_done wins, no timeout counted.
- PUSH (1 cycle):
  - !out_wrfull: out_wrreq=1, out_data=result.
  - out_wrfull: no write; overrun_cnt++.
  - Then -> IDLE.
- Latency tick->out_wrreq:
  - Bypass: 3 cycles (POP, LOAD, PUSH).
  - Effect: 4 + effect latency cycles.
  - Underrun: 1 cycle.
- Tick in any state other than IDLE: ignored for sequencing; tick_miss<=1 (sticky).
- enable falling mid-operation: current sample completes normally.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_stats has priority over a same-cycle increment.
- bypass and enable changes take effect only at LOAD or IDLE respectively; no glitching of in-flight samples.

Decomposition:
- Shared package (guitar_fx_pkg):
  - State enum (IDLE, POP, LOAD, RUN, PUSH).
  - DATA_W default.
  - Silence constant.
- Natural sub-module: sat_counter (CNT_W, inc, clr, count), instantiated three times.

Test Plan:
- Bypass: FIFO holds 32'h0000_1234, bypass=1, one tick -> out_wrreq 3 cycles later with out_data=32'h0000_1234; fx_start never pulses.
- Effect path: sample 32'h10, fx model returns 32'h20 after 5 cycles -> fx_start one cycle after LOAD; out_data=32'h20 pushed; busy low afterwards.
- Timeout: TIMEOUT=8, fx_done never asserted -> timeout_cnt=1; raw sample 32'h55 pushed; next tick processes normally.
- Underrun and overrun:
  - Empty FIFO, 3 ticks -> underrun_cnt=3 and three zero samples written.
  - out_wrfull=1 over 2 samples -> overrun_cnt=2, no out_wrreq.
- Missed tick and clear: tick while in RUN -> tick_miss=1; clr_stats in the same cycle as an overrun increment -> all counters 0.
- Reset mid-RUN: reset low -> outputs 0 immediately; after release, first tick processes a fresh sample.
- Saturation: force 2^CNT_W+2 underruns -> underrun_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/guitar_fx_pkg.sv
// Shared types and constants for the guitar effect sample path.
package guitar_fx_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;

    // Written to the output FIFO when a tick finds the input FIFO empty.
    localparam logic [DEFAULT_DATA_W-1:0] SILENCE = '0;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StRun,
        StPush
    } fx_state_e;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones; clear beats a same-cycle increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/effect_sample_scheduler.sv
// Per-tick sequencer: input FIFO -> effect datapath (or bypass) -> output FIFO,
// with an effect watchdog and saturating event counters.
module effect_sample_scheduler
    import guitar_fx_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              bypass,
    input  logic              sample_tick,
    input  logic              clr_stats,
    input  logic              in_rdempty,
    output logic              in_rdreq,
    input  logic [DATA_W-1:0] in_q,
    output logic              fx_start,
    output logic [DATA_W-1:0] fx_in,
    input  logic              fx_done,
    input  logic [DATA_W-1:0] fx_out,
    input  logic              out_wrfull,
    output logic              out_wrreq,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              tick_miss,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);

    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] SILENCE_W = DATA_W'(SILENCE);

    fx_state_e         state;
    logic [DATA_W-1:0] sample;
    logic [WD_W-1:0]   wd;

    logic tick_go;
    logic underrun_inc;
    logic overrun_inc;
    logic timeout_inc;

    assign tick_go      = (state == StIdle) && sample_tick && enable;
    assign underrun_inc = tick_go && in_rdempty;
    assign overrun_inc  = (state == StPush) && out_wrfull;
    assign timeout_inc  = (state == StRun) && !fx_done && (wd == WD_LAST);

    // Write strobe follows the FIFO full flag in the PUSH cycle itself.
    assign out_wrreq = (state == StPush) && !out_wrfull;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            in_rdreq <= 1'b0;
            fx_start <= 1'b0;
            fx_in    <= '0;
            out_data <= '0;
            sample   <= '0;
            wd       <= '0;
        end else begin
            in_rdreq <= 1'b0;
            fx_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick_go) begin
                        if (in_rdempty) begin
                            sample   <= SILENCE_W;
                            out_data <= SILENCE_W;
                            state    <= StPush;
                        end else begin
                            in_rdreq <= 1'b1;
                            state    <= StPop;
                        end
                    end
                end
                StPop: begin
                    state <= StLoad;
                end
                StLoad: begin
                    sample <= in_q;
                    if (bypass) begin
                        out_data <= in_q;
                        state    <= StPush;
                    end else begin
                        fx_in    <= in_q;
                        fx_start <= 1'b1;
                        wd       <= '0;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    // A completion on the expiry cycle still counts as a result.
                    if (fx_done) begin
                        out_data <= fx_out;
                        state    <= StPush;
                    end else if (wd == WD_LAST) begin
                        out_data <= sample;
                        state    <= StPush;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                StPush: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_miss <= 1'b0;
        end else if (clr_stats) begin
            tick_miss <= 1'b0;
        end else if (sample_tick && (state != StIdle)) begin
            tick_miss <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_underrun_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (underrun_inc),
        .clr   (clr_stats),
        .count (underrun_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_overrun_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (overrun_inc),
        .clr   (clr_stats),
        .count (overrun_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (timeout_inc),
        .clr   (clr_stats),
        .count (timeout_cnt)
    );

endmodule

// File: tb/tb_effect_sample_scheduler.sv
// Directed bench for effect_sample_scheduler with a one-cycle-latency FIFO
// and a fixed-latency effect model (result = sample * 2).
module tb_effect_sample_scheduler;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 8;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              bypass;
    logic              sample_tick;
    logic              clr_stats;
    logic              in_rdempty;
    logic              in_rdreq;
    logic [DATA_W-1:0] in_q;
    logic              fx_start;
    logic [DATA_W-1:0] fx_in;
    logic              fx_done;
    logic [DATA_W-1:0] fx_out;
    logic              out_wrfull;
    logic              out_wrreq;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              tick_miss;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  overrun_cnt;
    logic [CNT_W-1:0]  timeout_cnt;

    logic [DATA_W-1:0] fifo_data;
    logic              fx_en;
    int                fx_lat;
    int                fx_cnt;
    int                n_fx_start;
    int                vectors;
    int                miscompares;

    effect_sample_scheduler #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bypass       (bypass),
        .sample_tick  (sample_tick),
        .clr_stats    (clr_stats),
        .in_rdempty   (in_rdempty),
        .in_rdreq     (in_rdreq),
        .in_q         (in_q),
        .fx_start     (fx_start),
        .fx_in        (fx_in),
        .fx_done      (fx_done),
        .fx_out       (fx_out),
        .out_wrfull   (out_wrfull),
        .out_wrreq    (out_wrreq),
        .out_data     (out_data),
        .busy         (busy),
        .tick_miss    (tick_miss),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO read data is valid only in the cycle after the request.
    always @(posedge clk) begin
        in_q <= in_rdreq ? fifo_data : 32'hBAD0_BAD0;
    end

    // Effect model: fx_done fx_lat cycles after the fx_start cycle.
    always @(posedge clk) begin
        if (fx_start) begin
            fx_cnt     <= fx_lat;
            n_fx_start <= n_fx_start + 1;
        end else if (fx_cnt != 0) begin
            fx_cnt <= fx_cnt - 1;
        end
    end

    assign fx_done = fx_en && (fx_cnt == 1);
    assign fx_out  = fx_in << 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fx_cnt      = 0;
        n_fx_start  = 0;
        fx_en       = 1'b1;
        fx_lat      = 5;
        fifo_data   = '0;
        enable      = 1'b0;
        bypass      = 1'b0;
        sample_tick = 1'b0;
        clr_stats   = 1'b0;
        in_rdempty  = 1'b1;
        out_wrfull  = 1'b0;
        reset       = 1'b1;
        #2 reset = 1'b0;
        #1;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_strobes", {in_rdreq, fx_start, out_wrreq}, 0);
        check("rst_data", {fx_in, out_data}, 0);
        check("rst_cnts", {underrun_cnt, overrun_cnt, timeout_cnt, tick_miss}, 0);
        step();
        step();
        reset  = 1'b1;
        enable = 1'b1;
        step();

        // Bypass: tick -> POP, LOAD, PUSH
        fifo_data  = 32'h0000_1234;
        in_rdempty = 1'b0;
        bypass     = 1'b1;
        pulse_tick();
        in_rdempty = 1'b1;
        check("byp_pop", {busy, in_rdreq}, 2'b11);
        step();
        check("byp_load", {in_rdreq, out_wrreq}, 0);
        step();
        check("byp_wrreq", out_wrreq, 1);
        check("byp_data", out_data, 32'h0000_1234);
        step();
        check("byp_idle", {busy, out_wrreq}, 0);
        check("byp_no_fx", n_fx_start, 0);

        // Effect path, 5-cycle effect
        bypass     = 1'b0;
        fifo_data  = 32'h10;
        in_rdempty = 1'b0;
        fx_lat     = 5;
        pulse_tick();
        in_rdempty = 1'b1;
        step();
        step();
        check("fx_start", fx_start, 1);
        check("fx_in", fx_in, 32'h10);
        repeat (5) step();
        check("fx_wait", {out_wrreq, fx_start}, 0);
        check("fx_in_held", fx_in, 32'h10);
        step();
        check("fx_wrreq", out_wrreq, 1);
        check("fx_data", out_data, 32'h20);
        step();
        check("fx_idle", busy, 0);
        check("fx_starts", n_fx_start, 1);

        // Watchdog expiry: raw sample pushed after TIMEOUT RUN cycles
        fx_en      = 1'b0;
        fifo_data  = 32'h55;
        in_rdempty = 1'b0;
        pulse_tick();
        in_rdempty = 1'b1;
        repeat (9) step();
        check("to_wait", {busy, out_wrreq}, 2'b10);
        check("to_cnt0", timeout_cnt, 0);
        step();
        check("to_wrreq", out_wrreq, 1);
        check("to_data", out_data, 32'h55);
        check("to_cnt1", timeout_cnt, 1);
        step();
        check("to_idle", busy, 0);

        // fx_done on the expiry cycle wins
        fx_en      = 1'b1;
        fx_lat     = 7;
        fifo_data  = 32'h30;
        in_rdempty = 1'b0;
        pulse_tick();
        in_rdempty = 1'b1;
        repeat (10) step();
        check("edge_wrreq", out_wrreq, 1);
        check("edge_data", out_data, 32'h60);
        check("edge_to_cnt", timeout_cnt, 1);
        step();

        // Underrun: three ticks on an empty FIFO
        in_rdempty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check("und_wrreq", out_wrreq, 1);
            check("und_data", out_data, 0);
            step();
        end
        check("und_cnt", underrun_cnt, 3);

        // Disabled: tick ignored
        enable = 1'b0;
        pulse_tick();
        check("dis_idle", busy, 0);
        step();
        check("dis_cnt", underrun_cnt, 3);
        enable = 1'b1;

        // Overrun: output FIFO full for two samples
        bypass     = 1'b1;
        out_wrfull = 1'b1;
        fifo_data  = 32'h77;
        for (int i = 0; i < 2; i++) begin
            in_rdempty = 1'b0;
            pulse_tick();
            in_rdempty = 1'b1;
            step();
            step();
            check("ovr_no_wr", out_wrreq, 0);
            step();
        end
        check("ovr_cnt", overrun_cnt, 2);

        // Missed tick in RUN, then clear coincident with an overrun increment
        bypass     = 1'b0;
        fx_lat     = 5;
        fifo_data  = 32'h11;
        in_rdempty = 1'b0;
        pulse_tick();
        in_rdempty = 1'b1;
        check("miss_clear0", tick_miss, 0);
        step();
        step();
        step();
        pulse_tick();
        check("miss_set", tick_miss, 1);
        check("miss_busy", busy, 1);
        repeat (4) step();
        check("miss_push_blocked", out_wrreq, 0);
        check("miss_data", out_data, 32'h22);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr_cnts", {underrun_cnt, overrun_cnt, timeout_cnt, tick_miss}, 0);
        check("clr_idle", busy, 0);

        // Reset in the middle of RUN
        out_wrfull = 1'b0;
        fifo_data  = 32'h99;
        in_rdempty = 1'b0;
        pulse_tick();
        in_rdempty = 1'b1;
        repeat (4) step();
        check("pre_rst_run", {busy, fx_in}, {1'b1, 32'h99});
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", {fx_in, out_data}, 0);
        check("mid_rst_strobes", {in_rdreq, fx_start, out_wrreq}, 0);
        repeat (8) step();
        reset = 1'b1;
        step();
        fifo_data  = 32'h40;
        in_rdempty = 1'b0;
        pulse_tick();
        in_rdempty = 1'b1;
        repeat (8) step();
        check("fresh_wrreq", out_wrreq, 1);
        check("fresh_data", out_data, 32'h80);
        check("fresh_starts", n_fx_start, 6);
        step();

        // Saturation: 2^CNT_W + 2 underruns
        in_rdempty = 1'b1;
        for (int i = 0; i < 255; i++) begin
            pulse_tick();
            step();
        end
        check("sat_full", underrun_cnt, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            step();
        end
        check("sat_hold", underrun_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
